// File: rtl/calc_accum_seq_pkg.sv
// Shared types for the calculator accumulator: opcode encoding and FSM states.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/calc_accum_seq_if.sv
// Operand/opcode handshake plus status outputs of the accumulator.
// The master offers operands; the slave (accumulator) reports results.
interface calc_accum_seq_if #(
    parameter int WIDTH = 8
);
    import calc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             done;
    logic             busy;

    modport master (
        output in_valid, op, operand,
        input  in_ready, acc, carry, ovf, zero, done, busy
    );

    modport slave (
        input  in_valid, op, operand,
        output in_ready, acc, carry, ovf, zero, done, busy
    );

endinterface

// File: rtl/calc_accum_seq_cla.sv
// Combinational CHUNK-bit carry-lookahead adder slice.
// Every carry is expanded directly from generate/propagate terms and ci,
// so no carry depends on a lower-order carry signal.
module cla_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK:0]   w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, built per bit.
    always_comb begin : carry_lookahead
        logic v_term;
        v_term = 1'b0;
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            v_term = ci;
            for (int j = 0; j <= i; j++) begin
                v_term = w_g[j] | (w_p[j] & v_term);
            end
            w_c[i+1] = v_term;
        end
    end

    assign s  = w_p ^ w_c[CHUNK-1:0];
    assign co = w_c[CHUNK];

endmodule

// File: rtl/calc_accum_seq.sv
// Chunked accumulator: ADD/SUB run CHUNK bits per cycle through one CLA slice,
// holding the inter-chunk carry in a register; LOAD/CLR commit in one cycle.
module calc_accum_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic            hz100,
    input  logic            reset,
    calc_accum_seq_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cin;
    logic             r_carry;
    logic             r_ovf;
    logic             r_done;
    logic [IDXW-1:0]  r_idx;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s_chunk;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_full;
    logic             w_ovf;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_chunk = r_acc[int'(r_idx)*CHUNK +: CHUNK];
    assign w_b_chunk = r_opb[int'(r_idx)*CHUNK +: CHUNK];

    cla_slice #(.CHUNK(CHUNK)) u_cla (
        .a  (w_a_chunk),
        .b  (w_b_chunk),
        .ci (r_cin),
        .s  (w_s_chunk),
        .co (w_co)
    );

    // Full result as it will look once the current chunk lands in the shadow register.
    always_comb begin
        w_sum_full = r_sum;
        w_sum_full[int'(r_idx)*CHUNK +: CHUNK] = w_s_chunk;
    end

    // Signed overflow uses the pre-commit accumulator and the (possibly inverted) operand.
    assign w_ovf = (r_acc[MSB] == r_opb[MSB]) & (w_sum_full[MSB] != r_acc[MSB]);

    // State register; reset aborts any chunk sequence in flight.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: ADD/SUB enter RUN, LOAD/CLR stay in IDLE, RUN leaves after the last chunk.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.in_valid;
                if (bus.in_valid && ((bus.op == OP_ADD) || (bus.op == OP_SUB))) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, chunk-by-chunk sum into the shadow, and commit.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_acc   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (bus.op)
                            OP_ADD: begin
                                r_opb <= bus.operand;
                                r_cin <= 1'b0;
                                r_idx <= '0;
                            end
                            OP_SUB: begin
                                r_opb <= ~bus.operand;
                                r_cin <= 1'b1;
                                r_idx <= '0;
                            end
                            OP_LOAD: begin
                                r_acc   <= bus.operand;
                                r_carry <= 1'b0;
                                r_ovf   <= 1'b0;
                                r_done  <= 1'b1;
                            end
                            OP_CLR: begin
                                r_acc   <= '0;
                                r_carry <= 1'b0;
                                r_ovf   <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    r_sum <= w_sum_full;
                    r_cin <= w_co;
                    if (w_last) begin
                        r_acc   <= w_sum_full;
                        r_carry <= w_co;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == IDLE);
    assign bus.busy     = (r_state != IDLE);
    assign bus.acc      = r_acc;
    assign bus.carry    = r_carry;
    assign bus.ovf      = r_ovf;
    assign bus.zero     = (r_acc == '0);
    assign bus.done     = r_done;

endmodule

// File: tb/tb_calc_accum_seq.sv
// Self-checking bench for calc_accum_seq. Three instances share one stimulus
// bus: 8-bit/4-bit chunks, 16-bit/4-bit chunks, and 8-bit single-chunk.
// A selector picks which instance's outputs are compared for each vector.
module tb_calc_accum_seq;
    import calc_pkg::*;

    typedef struct {
        int          sel;
        op_t         op;
        logic [15:0] operand;
        logic [15:0] expAcc;
        logic        expCarry;
        logic        expOvf;
        logic        expZero;
        int          expBusy;
    } vec_t;

    typedef struct packed {
        logic [15:0] acc;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        done;
        logic        busy;
        logic        inReady;
    } mon_t;

    logic        hz100 = 1'b0;
    logic        reset;
    logic        tbValid;
    op_t         tbOp;
    logic [15:0] tbOperand;
    int          sel;
    mon_t        mon;
    int          tests = 0;
    int          fails = 0;
    vec_t        vecs[$];

    calc_accum_seq_if #(.WIDTH(8))  if8 ();
    calc_accum_seq_if #(.WIDTH(16)) if16 ();
    calc_accum_seq_if #(.WIDTH(8))  if1 ();

    assign if8.in_valid  = tbValid;
    assign if8.op        = tbOp;
    assign if8.operand   = tbOperand[7:0];
    assign if16.in_valid = tbValid;
    assign if16.op       = tbOp;
    assign if16.operand  = tbOperand;
    assign if1.in_valid  = tbValid;
    assign if1.op        = tbOp;
    assign if1.operand   = tbOperand[7:0];

    calc_accum_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
        .hz100 (hz100),
        .reset (reset),
        .bus   (if8)
    );

    calc_accum_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .hz100 (hz100),
        .reset (reset),
        .bus   (if16)
    );

    calc_accum_seq #(.WIDTH(8), .CHUNK(8)) dut1 (
        .hz100 (hz100),
        .reset (reset),
        .bus   (if1)
    );

    always #5 hz100 = ~hz100;

    // Route the selected instance's outputs into one zero-extended record.
    always_comb begin
        mon = '0;
        case (sel)
            0: mon = {8'h00, if8.acc, if8.carry, if8.ovf, if8.zero, if8.done, if8.busy, if8.in_ready};
            1: mon = {if16.acc, if16.carry, if16.ovf, if16.zero, if16.done, if16.busy, if16.in_ready};
            2: mon = {8'h00, if1.acc, if1.carry, if1.ovf, if1.zero, if1.done, if1.busy, if1.in_ready};
            default: mon = '0;
        endcase
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no summary, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input int s, input op_t o, input logic [15:0] opnd, input logic [15:0] a,
                          input logic c, input logic v, input logic z, input int b);
        vec_t t;
        t.sel      = s;
        t.op       = o;
        t.operand  = opnd;
        t.expAcc   = a;
        t.expCarry = c;
        t.expOvf   = v;
        t.expZero  = z;
        t.expBusy  = b;
        vecs.push_back(t);
    endtask

    // Wait for in_ready, offer one operation for one edge, then count busy cycles until done.
    task automatic applyStimulus(input int s, input op_t o, input logic [15:0] val,
                                 output int busyCnt, output bit gotDone);
        bit sawReady;
        sel      = s;
        sawReady = 1'b0;
        busyCnt  = 0;
        gotDone  = 1'b0;
        @(negedge hz100);
        for (int k = 0; k < 40; k++) begin
            if (mon.inReady) begin
                sawReady = 1'b1;
                break;
            end
            @(negedge hz100);
        end
        checkOutput($sformatf("ready wait dut%0d", s), {31'd0, sawReady}, 32'd1);
        tbValid   = 1'b1;
        tbOp      = o;
        tbOperand = val;
        @(posedge hz100);
        #1 tbValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge hz100);
            if (mon.done) begin
                gotDone = 1'b1;
                break;
            end
            if (mon.busy) busyCnt++;
        end
    endtask

    initial begin
        int          busyCnt;
        bit          gotDone;
        int          doneCount;
        int          busySeen;
        logic [15:0] firstDoneAcc;
        bit          runAccBad;

        reset     = 1'b0;
        tbValid   = 1'b0;
        tbOp      = OP_ADD;
        tbOperand = 16'h0000;
        sel       = 0;

        // 8-bit, two chunks
        addVec(0, OP_LOAD, 16'h007F, 16'h007F, 1'b0, 1'b0, 1'b0, 0);
        addVec(0, OP_ADD,  16'h0001, 16'h0080, 1'b0, 1'b1, 1'b0, 2);
        addVec(0, OP_LOAD, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, 0);
        addVec(0, OP_ADD,  16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
        addVec(0, OP_LOAD, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 0);
        addVec(0, OP_SUB,  16'h0007, 16'h00FE, 1'b0, 1'b0, 1'b0, 2);
        addVec(0, OP_SUB,  16'h00FE, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
        addVec(0, OP_LOAD, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0, 0);
        addVec(0, OP_SUB,  16'h0001, 16'h007F, 1'b1, 1'b1, 1'b0, 2);
        addVec(0, OP_ADD,  16'h003C, 16'h00BB, 1'b0, 1'b1, 1'b0, 2);
        addVec(0, OP_LOAD, 16'h0012, 16'h0012, 1'b0, 1'b0, 1'b0, 0);
        addVec(0, OP_ADD,  16'h000F, 16'h0021, 1'b0, 1'b0, 1'b0, 2);
        addVec(0, OP_CLR,  16'h0055, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        addVec(0, OP_ADD,  16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, 2);
        addVec(0, OP_ADD,  16'h00FF, 16'h00FE, 1'b1, 1'b0, 1'b0, 2);
        addVec(0, OP_CLR,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        // 16-bit, four chunks
        addVec(1, OP_LOAD, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0, 0);
        addVec(1, OP_ADD,  16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 4);
        addVec(1, OP_LOAD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        addVec(1, OP_ADD,  16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 4);
        addVec(1, OP_LOAD, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 0);
        addVec(1, OP_SUB,  16'h0235, 16'h0FFF, 1'b1, 1'b0, 1'b0, 4);
        addVec(1, OP_ADD,  16'h7001, 16'h8000, 1'b0, 1'b1, 1'b0, 4);
        // 8-bit, single chunk
        addVec(2, OP_LOAD, 16'h007F, 16'h007F, 1'b0, 1'b0, 1'b0, 0);
        addVec(2, OP_ADD,  16'h0001, 16'h0080, 1'b0, 1'b1, 1'b0, 1);
        addVec(2, OP_SUB,  16'h0081, 16'h00FF, 1'b0, 1'b0, 1'b0, 1);
        addVec(2, OP_ADD,  16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1);

        // Reset state, both while held and after release.
        repeat (2) @(negedge hz100);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("in-reset acc dut%0d", s), {16'd0, mon.acc}, 32'd0);
            checkOutput($sformatf("in-reset zero dut%0d", s), {31'd0, mon.zero}, 32'd1);
            checkOutput($sformatf("in-reset ready dut%0d", s), {31'd0, mon.inReady}, 32'd1);
        end
        @(negedge hz100);
        reset = 1'b1;
        @(negedge hz100);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("reset acc dut%0d", s), {16'd0, mon.acc}, 32'd0);
            checkOutput($sformatf("reset zero dut%0d", s), {31'd0, mon.zero}, 32'd1);
            checkOutput($sformatf("reset carry dut%0d", s), {31'd0, mon.carry}, 32'd0);
            checkOutput($sformatf("reset ovf dut%0d", s), {31'd0, mon.ovf}, 32'd0);
            checkOutput($sformatf("reset ready dut%0d", s), {31'd0, mon.inReady}, 32'd1);
            checkOutput($sformatf("reset done dut%0d", s), {31'd0, mon.done}, 32'd0);
            checkOutput($sformatf("reset busy dut%0d", s), {31'd0, mon.busy}, 32'd0);
        end

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].op, vecs[i].operand, busyCnt, gotDone);
            checkOutput($sformatf("v%0d done seen", i), {31'd0, gotDone}, 32'd1);
            checkOutput($sformatf("v%0d busy cycles", i), busyCnt, vecs[i].expBusy);
            checkOutput($sformatf("v%0d acc", i), {16'd0, mon.acc}, {16'd0, vecs[i].expAcc});
            checkOutput($sformatf("v%0d carry", i), {31'd0, mon.carry}, {31'd0, vecs[i].expCarry});
            checkOutput($sformatf("v%0d ovf", i), {31'd0, mon.ovf}, {31'd0, vecs[i].expOvf});
            checkOutput($sformatf("v%0d zero", i), {31'd0, mon.zero}, {31'd0, vecs[i].expZero});
            checkOutput($sformatf("v%0d ready in done cycle", i), {31'd0, mon.inReady}, 32'd1);
            @(negedge hz100);
            checkOutput($sformatf("v%0d done one cycle", i), {31'd0, mon.done}, 32'd0);
        end

        // Second ADD held on in_valid during RUN of the first; taken only in the done cycle.
        applyStimulus(0, OP_CLR, 16'h0000, busyCnt, gotDone);
        checkOutput("hold clr acc", {16'd0, mon.acc}, 32'd0);
        @(negedge hz100);
        tbValid   = 1'b1;
        tbOp      = OP_ADD;
        tbOperand = 16'h0001;
        @(posedge hz100);
        #1 tbOperand = 16'h0010;
        doneCount    = 0;
        busySeen     = 0;
        firstDoneAcc = 16'hFFFF;
        runAccBad    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge hz100);
            if (mon.done) begin
                doneCount++;
                if (doneCount == 1) firstDoneAcc = mon.acc;
            end
            if (mon.busy) begin
                busySeen++;
                if (mon.acc != ((doneCount == 0) ? 16'h0000 : 16'h0001)) runAccBad = 1'b1;
            end
            if (mon.inReady && tbValid) begin
                @(posedge hz100);
                #1 tbValid = 1'b0;
            end
        end
        checkOutput("hold done pulses", doneCount, 2);
        checkOutput("hold first commit acc", {16'd0, firstDoneAcc}, 32'h01);
        checkOutput("hold final acc", {16'd0, mon.acc}, 32'h11);
        checkOutput("hold busy cycles", busySeen, 4);
        checkOutput("hold acc stable in RUN", {31'd0, runAccBad}, 32'd0);

        // Reset during the second RUN cycle of a 16-bit ADD aborts at once.
        applyStimulus(1, OP_LOAD, 16'h00FF, busyCnt, gotDone);
        checkOutput("abort pre-load acc", {16'd0, mon.acc}, 32'h00FF);
        @(negedge hz100);
        tbValid   = 1'b1;
        tbOp      = OP_ADD;
        tbOperand = 16'h0001;
        @(posedge hz100);
        #1 tbValid = 1'b0;
        @(negedge hz100);
        checkOutput("abort busy before reset", {31'd0, mon.busy}, 32'd1);
        @(posedge hz100);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort acc cleared", {16'd0, mon.acc}, 32'd0);
        checkOutput("abort busy low", {31'd0, mon.busy}, 32'd0);
        checkOutput("abort ready high", {31'd0, mon.inReady}, 32'd1);
        checkOutput("abort done low", {31'd0, mon.done}, 32'd0);
        reset = 1'b1;
        applyStimulus(1, OP_LOAD, 16'h1234, busyCnt, gotDone);
        checkOutput("post-abort load done", {31'd0, gotDone}, 32'd1);
        checkOutput("post-abort load acc", {16'd0, mon.acc}, 32'h1234);
        checkOutput("post-abort load busy", busyCnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
